io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped responder for the CPU IO bus (io_addr / io_dout / io_we / io_din / io_rd), owning the device side of every IO transaction the CPU initiates. It holds the LED register, a one-entry output buffer toward the display path, a one-entry input buffer fed from the switch-entry path, a status register and a free-running cycle counter. It sits between the CPU IO bus and the PDU's input/display logic, replacing ad-hoc address decoding inside the PDU.

## Interface

Parameters:
- CNT_W, 32, cycle-counter width; readback is zero-extended to 32 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- io_addr  in  8  byte address from CPU
- io_dout  in  32  write data from CPU
- io_we  in  1  write strobe from CPU
- io_rd  in  1  read strobe from CPU; gates read side effects only
- io_din  out  32  read data to CPU
- led  out  16  LED register
- in_data  in  32  input word from the switch-entry path
- in_valid  in  1  input word offered
- in_ready  out  1  input buffer empty
- out_data  out  32  output word to display path
- out_valid  out  1  output buffer full
- out_ready  in  1  display path accepts the word

## Operation

Address map (full 8-bit decode; any other address is unmapped: reads return 0, writes are ignored):
- 0x00 LED, R/W: write loads io_dout[15:0] into led; read returns {16'b0, led}.
- 0x04 STATUS, R/W1C: bit0 out_empty (= ~out_full), bit1 in_full, bit2 out_err (sticky). Writing 1 to bit2 clears out_err; other bits are read-only.
- 0x08 OUT_DATA, W: if the output buffer is empty, or a display transfer completes on the same edge, load io_dout and set out_full. Otherwise leave the buffer unchanged and set out_err. Reads return the buffer contents.
- 0x0C IN_DATA, R: returns the input buffer. With io_rd asserted, in_full is cleared on that edge. Reads with io_rd low have no side effect.
- 0x10 CYCLES, R: free-running counter, +1 every cycle, wraps from all-ones to 0.

Buffer handshakes:
- Input buffer: a transfer occurs when in_valid && in_ready at a rising edge. The buffer latches in_data and sets in_full. in_ready = ~in_full.
- Output buffer: a transfer occurs when out_valid && out_ready at a rising edge; out_full clears. out_valid = out_full, and out_data is the buffer register.
- io_we and io_rd in the same cycle: both take effect.
- A CPU read of IN_DATA clears in_full on the same edge. Because in_ready is low in that cycle, no push occurs then; the next push is accepted one cycle later.

Reset (asynchronous; immediately on assertion, mid-transaction included): led=0, out buffer=0, out_full=0, in buffer=0, in_full=0, out_err=0, counter=0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, led=0, io_din=0 for all addresses except 0x04, which reads 0x1.

## Timing

- io_din is combinational from io_addr and the current register state. The CPU samples it in the same cycle (single-cycle read).
- Writes and read side effects take effect at the rising edge where the strobe is high, and are visible on io_din the following cycle.
- Handshake outputs (in_ready, out_valid) are derived only from registers and have no combinational path from in_valid or out_ready.
- Output path throughput is 1 word/cycle when the CPU writes on each transfer edge. Input path throughput is 1 word per 2 cycles minimum.

## Structure

- Shared package io_map_pkg: address constants (IO_LED, IO_STATUS, IO_OUT_DATA, IO_IN_DATA, IO_CYCLES) and status bit indices (ST_OUT_EMPTY, ST_IN_FULL, ST_OUT_ERR). The CPU-side test programs and the PDU use the same package.
- One sub-module, io_slot: a one-entry 32-bit buffer with push/pop/full. It is instantiated twice, once for the input buffer and once for the output buffer. Decode, LED register, status register and counter stay in io_responder.

## Test plan

- Reset mid-stream: assert rst while out_full=1 and in_full=1 -> same cycle out_valid=0, in_ready=1, read of 0x04 = 0x1, read of 0x10 = 0.
- LED write of io_dout=0xABCD1234 to 0x00 -> led=0x1234 next cycle; read of 0x00 = 0x00001234.
- Output overflow: write 0x11 to 0x08 with out_ready=0, then write 0x22 -> out_data stays 0x11; STATUS = 0x4 (bit2 set, bit0 clear). Write 0x4 to 0x04 -> STATUS = 0x0. Raise out_ready -> STATUS = 0x1 next cycle.
- Simultaneous write and drain: out_full=1 holding 0x11, out_ready=1 and write 0x22 to 0x08 on the same edge -> out_valid stays 1, out_data=0x22, out_err stays 0.
- Input path: push 0x55 -> in_ready=0 and STATUS bit1=1. Hold in_valid with 0x66 and read 0x0C with io_rd=1 -> io_din=0x55. Next edge in_full=0, and 0x66 is accepted one edge after that. Reading 0x0C with io_rd=0 never clears in_full.
- Counter wrap: with CNT_W=4, 16 cycles after reset, read 0x10 -> 0x0 again; an unmapped read at 0x14 returns 0.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: IO bus address map, status bit layout and status word packing
package io_map_pkg;
  localparam logic [7:0] IO_LED      = 8'h00;
  localparam logic [7:0] IO_STATUS   = 8'h04;
  localparam logic [7:0] IO_OUT_DATA = 8'h08;
  localparam logic [7:0] IO_IN_DATA  = 8'h0C;
  localparam logic [7:0] IO_CYCLES   = 8'h10;
  localparam int ST_OUT_EMPTY = 0;
  localparam int ST_IN_FULL   = 1;
  localparam int ST_OUT_ERR   = 2;
  typedef logic [31:0] word_t;
  function automatic word_t status_word(input logic out_full, input logic in_full, input logic out_err);
    word_t w;
    w = '0;
    w[ST_OUT_EMPTY] = ~out_full;
    w[ST_IN_FULL]   = in_full;
    w[ST_OUT_ERR]   = out_err;
    return w;
  endfunction
endpackage

// File: rtl/io_slot.sv
// io_slot: one-entry 32-bit buffer; a push wins over a same-edge pop so the slot stays full with new data
module io_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] data,
  output logic        full
);
  // capture on push, release on pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (push) begin
      data <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: CPU IO bus responder with LED, status, in/out buffers and cycle counter
module io_responder
  import io_map_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  output logic [15:0] led,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  logic [31:0]      in_buf;
  logic             in_full;
  logic             out_full;
  logic             out_err;
  logic [CNT_W-1:0] cnt;
  logic             wr_led;
  logic             wr_st;
  logic             wr_out;
  logic             in_push;
  logic             in_pop;
  logic             out_pop;
  logic             out_push;
  assign wr_led   = io_we && io_addr == IO_LED;
  assign wr_st    = io_we && io_addr == IO_STATUS;
  assign wr_out   = io_we && io_addr == IO_OUT_DATA;
  assign in_ready = ~in_full;
  assign in_push  = in_valid && in_ready;
  assign in_pop   = io_rd && io_addr == IO_IN_DATA;
  assign out_valid = out_full;
  assign out_pop  = out_full && out_ready;
  assign out_push = wr_out && (!out_full || out_pop);
  io_slot u_in (
    .clk  (clk),
    .rst  (rst),
    .push (in_push),
    .pop  (in_pop),
    .din  (in_data),
    .data (in_buf),
    .full (in_full)
  );
  io_slot u_out (
    .clk  (clk),
    .rst  (rst),
    .push (out_push),
    .pop  (out_pop),
    .din  (io_dout),
    .data (out_data),
    .full (out_full)
  );
  // LED register takes the low half of the write word
  always_ff @(posedge clk or posedge rst)
    if (rst) led <= '0;
    else if (wr_led) led <= io_dout[15:0];
  // sticky overflow flag: set by a write into a full, non-draining buffer; cleared by W1C
  always_ff @(posedge clk or posedge rst)
    if (rst) out_err <= 1'b0;
    else if (wr_out && out_full && !out_ready) out_err <= 1'b1;
    else if (wr_st && io_dout[ST_OUT_ERR]) out_err <= 1'b0;
  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  // single-cycle read mux; unmapped addresses read as zero
  always_comb
    io_din = io_addr == IO_LED      ? {16'b0, led} :
             io_addr == IO_STATUS   ? status_word(out_full, in_full, out_err) :
             io_addr == IO_OUT_DATA ? out_data :
             io_addr == IO_IN_DATA  ? in_buf :
             io_addr == IO_CYCLES   ? 32'(cnt) : '0;
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: vector table plus reset and counter-wrap sequences, checked through a scoreboard queue
module tb_io_responder;
  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_dout = '0;
  logic        io_we = 0;
  logic        io_rd = 0;
  logic [31:0] io_din;
  logic [15:0] led;
  logic [31:0] in_data = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 0;
  int n_cmp = 0;
  int n_err = 0;

  io_responder #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .led(led), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] dout;
    logic        we, rd;
    logic [31:0] idata;
    logic        ival, ordy;
    logic [31:0] e_din;
    logic [15:0] e_led;
    logic        e_in_ready, e_out_valid;
    logic [31:0] e_out_data;
  } vec_t;

  typedef struct {
    logic [31:0] din;
    logic [15:0] led;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
  } exp_t;

  vec_t vecs[25];
  exp_t sb[$];

  function automatic vec_t mk(logic [7:0] a, logic [31:0] d, logic w, logic r, logic [31:0] id,
                              logic iv, logic ordy, logic [31:0] ed, logic [15:0] el,
                              logic eir, logic eov, logic [31:0] eod);
    vec_t v;
    v.addr = a; v.dout = d; v.we = w; v.rd = r; v.idata = id; v.ival = iv; v.ordy = ordy;
    v.e_din = ed; v.e_led = el; v.e_in_ready = eir; v.e_out_valid = eov; v.e_out_data = eod;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_pop(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_io_din", idx), io_din, e.din);
    chk($sformatf("v%0d_led", idx), {16'b0, led}, {16'b0, e.led});
    chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, {31'b0, e.in_ready});
    chk($sformatf("v%0d_out_valid", idx), {31'b0, out_valid}, {31'b0, e.out_valid});
    chk($sformatf("v%0d_out_data", idx), out_data, e.out_data);
  endtask

  initial begin
    vecs[0]  = mk(8'h00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 1, 0, 32'h0);
    vecs[1]  = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h1, 16'h0, 1, 0, 32'h0);
    vecs[2]  = mk(8'h00, 32'hABCD1234, 1, 0, 0, 0, 0, 32'h0, 16'h0, 1, 0, 32'h0);
    vecs[3]  = mk(8'h00, 0, 0, 1, 0, 0, 0, 32'h1234, 16'h1234, 1, 0, 32'h0);
    vecs[4]  = mk(8'h08, 32'h11, 1, 0, 0, 0, 0, 32'h0, 16'h1234, 1, 0, 32'h0);
    vecs[5]  = mk(8'h08, 32'h22, 1, 0, 0, 0, 0, 32'h11, 16'h1234, 1, 1, 32'h11);
    vecs[6]  = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h4, 16'h1234, 1, 1, 32'h11);
    vecs[7]  = mk(8'h04, 32'h4, 1, 0, 0, 0, 0, 32'h4, 16'h1234, 1, 1, 32'h11);
    vecs[8]  = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h0, 16'h1234, 1, 1, 32'h11);
    vecs[9]  = mk(8'h04, 0, 0, 1, 0, 0, 1, 32'h0, 16'h1234, 1, 1, 32'h11);
    vecs[10] = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h1, 16'h1234, 1, 0, 32'h11);
    vecs[11] = mk(8'h08, 32'h33, 1, 0, 0, 0, 0, 32'h11, 16'h1234, 1, 0, 32'h11);
    vecs[12] = mk(8'h08, 32'h44, 1, 0, 0, 0, 1, 32'h33, 16'h1234, 1, 1, 32'h33);
    vecs[13] = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h0, 16'h1234, 1, 1, 32'h44);
    vecs[14] = mk(8'h0C, 0, 0, 0, 32'h55, 1, 1, 32'h0, 16'h1234, 1, 1, 32'h44);
    vecs[15] = mk(8'h04, 0, 0, 1, 32'h66, 1, 0, 32'h3, 16'h1234, 0, 0, 32'h44);
    vecs[16] = mk(8'h0C, 0, 0, 0, 32'h66, 1, 0, 32'h55, 16'h1234, 0, 0, 32'h44);
    vecs[17] = mk(8'h0C, 0, 0, 1, 32'h66, 1, 0, 32'h55, 16'h1234, 0, 0, 32'h44);
    vecs[18] = mk(8'h0C, 0, 0, 0, 32'h66, 1, 0, 32'h55, 16'h1234, 1, 0, 32'h44);
    vecs[19] = mk(8'h0C, 0, 0, 0, 32'h0, 0, 0, 32'h66, 16'h1234, 0, 0, 32'h44);
    vecs[20] = mk(8'h14, 0, 0, 1, 0, 0, 0, 32'h0, 16'h1234, 0, 0, 32'h44);
    vecs[21] = mk(8'h0C, 32'hDEAD, 1, 1, 0, 0, 0, 32'h66, 16'h1234, 0, 0, 32'h44);
    vecs[22] = mk(8'h04, 0, 0, 1, 0, 0, 0, 32'h1, 16'h1234, 1, 0, 32'h44);
    vecs[23] = mk(8'h14, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h0, 16'h1234, 1, 0, 32'h44);
    vecs[24] = mk(8'h00, 0, 0, 1, 0, 0, 0, 32'h1234, 16'h1234, 1, 0, 32'h44);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 25; i++) begin
      exp_t e;
      io_addr = vecs[i].addr; io_dout = vecs[i].dout; io_we = vecs[i].we; io_rd = vecs[i].rd;
      in_data = vecs[i].idata; in_valid = vecs[i].ival; out_ready = vecs[i].ordy;
      e.din = vecs[i].e_din; e.led = vecs[i].e_led; e.in_ready = vecs[i].e_in_ready;
      e.out_valid = vecs[i].e_out_valid; e.out_data = vecs[i].e_out_data;
      sb.push_back(e);
      @(negedge clk);
      check_pop(i);
      @(posedge clk);
      #1;
    end
    io_addr = 8'h08; io_dout = 32'h88; io_we = 1; io_rd = 0;
    in_data = 32'h77; in_valid = 1; out_ready = 0;
    @(posedge clk);
    #1 io_we = 0; in_valid = 0; io_addr = 8'h04;
    @(negedge clk);
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
    chk("pre_rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("pre_rst_status", io_din, 32'h2);
    #1 rst = 1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_status", io_din, 32'h1);
    io_addr = 8'h10;
    #1 chk("rst_cycles", io_din, 32'h0);
    @(negedge clk);
    rst = 0;
    #1 chk("cyc_0", io_din, 32'h0);
    repeat (5) @(posedge clk);
    #1 chk("cyc_5", io_din, 32'h5);
    repeat (11) @(posedge clk);
    #1 chk("cyc_wrap", io_din, 32'h0);
    io_addr = 8'h14;
    #1 chk("unmapped_14", io_din, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
